led_strand_driver: RTL and testbench

- Drives the single-wire WS2811-style LED strand during calibration and normal display.
- Walks LED addresses 0..NUM_LEDS-1 on next_led_request and samples the 24-bit colour returned by the colour source (the id shower or display pattern generator).
- Serialises each colour MSB-first in GRB order using cycle-counted high/low pulse widths.
- Ends each frame with a latch gap and pulses frame_done; the colour source counts the request edge leaving address 0 as the start of a frame.

---
 rtl/led_pkg.sv | 43 ++++
 rtl/led_strand_driver_pulse_timer.sv | 37 +++
 rtl/led_strand_driver.sv | 138 +++++++++++++
 tb/tb_led_strand_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and defaults for the WS2811-style strand driver.
// Defaults assume a 100 MHz clock.
package led_pkg;

  typedef enum logic [1:0] {
    FRAME_GAP,
    WAIT_COLOR,
    SEND_HIGH,
    SEND_LOW
  } led_state_e;

  localparam int COLOR_BITS = 24;
  localparam int BIT_IDX_W  = $clog2(COLOR_BITS);

  localparam int DEF_NUM_LEDS     = 50;
  localparam int DEF_T0H_CYCLES   = 35;
  localparam int DEF_T0L_CYCLES   = 80;
  localparam int DEF_T1H_CYCLES   = 70;
  localparam int DEF_T1L_CYCLES   = 60;
  localparam int DEF_RESET_CYCLES = 6000;
  localparam int DEF_REQ_LATENCY  = 2;

  // The strand expects green first, then red, then blue, each MSB-first.
  function automatic logic [COLOR_BITS-1:0] pack_grb(input logic [7:0] green,
                                                     input logic [7:0] red,
                                                     input logic [7:0] blue);
    return {green, red, blue};
  endfunction

  // The latency count is also loaded into the timer, so it joins the max.
  function automatic int timer_width(input int gap, input int t0h, input int t0l,
                                     input int t1h, input int t1l, input int lat);
    int m;
    m = gap;
    if (t0h > m) m = t0h;
    if (t0l > m) m = t0l;
    if (t1h > m) m = t1h;
    if (t1l > m) m = t1l;
    if (lat > m) m = lat;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/led_strand_driver_pulse_timer.sv
// Loadable down-counter: load with duration-1, done while the count sits at 0.
// done_next predicts done for the following cycle so callers can register it.
module pulse_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done,
  output logic             done_next
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count;
    if (load)
      count_d = load_value;
    else if (count != '0)
      count_d = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for state so all flops update from pre-edge values.
    if (rst)
      count <= '0;
    else
      count <= count_d;
  end

  assign done      = (count == '0);
  assign done_next = (count_d == '0);

endmodule

// File: rtl/led_strand_driver.sv
// Single-wire LED strand driver: fetches one GRB colour per LED, serialises it
// with cycle-counted pulse widths and closes each frame with a latch gap.
module led_strand_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS          = DEF_NUM_LEDS,
  parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
  parameter int T0H_CYCLES        = DEF_T0H_CYCLES,
  parameter int T0L_CYCLES        = DEF_T0L_CYCLES,
  parameter int T1H_CYCLES        = DEF_T1H_CYCLES,
  parameter int T1L_CYCLES        = DEF_T1L_CYCLES,
  parameter int RESET_CYCLES      = DEF_RESET_CYCLES,
  parameter int REQ_LATENCY       = DEF_REQ_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
  output logic                         strand_out,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int TIMER_W = timer_width(RESET_CYCLES, T0H_CYCLES, T0L_CYCLES,
                                       T1H_CYCLES, T1L_CYCLES, REQ_LATENCY);
  localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_LED = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

  led_state_e                   state, state_d;
  logic [COLOR_BITS-1:0]        shreg, shreg_d;
  logic [BIT_IDX_W-1:0]         bit_idx, bit_idx_d;
  logic [LED_ADDRESS_WIDTH-1:0] led_idx_d;
  logic                         gap_armed;
  logic                         timer_load;
  logic [TIMER_W-1:0]           timer_value;
  logic                         timer_done, timer_done_next;

  function automatic logic [TIMER_W-1:0] high_time(input logic b);
    return b ? TIMER_W'(T1H_CYCLES - 1) : TIMER_W'(T0H_CYCLES - 1);
  endfunction

  function automatic logic [TIMER_W-1:0] low_time(input logic b);
    return b ? TIMER_W'(T1L_CYCLES - 1) : TIMER_W'(T0L_CYCLES - 1);
  endfunction

  pulse_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done),
    .done_next  (timer_done_next)
  );

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_idx_d   = bit_idx;
    led_idx_d   = next_led_request;
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state)
      FRAME_GAP: begin
        // Out of reset the timer sits at 0; the first gap cycle arms it instead.
        if (!gap_armed) begin
          timer_load  = 1'b1;
          timer_value = TIMER_W'(RESET_CYCLES - 2);
        end else if (timer_done) begin
          state_d     = WAIT_COLOR;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(REQ_LATENCY);
        end
      end
      WAIT_COLOR: begin
        if (timer_done && color_valid) begin
          shreg_d     = pack_grb(green_in, red_in, blue_in);
          bit_idx_d   = BIT_IDX_W'(COLOR_BITS - 1);
          state_d     = SEND_HIGH;
          timer_load  = 1'b1;
          timer_value = high_time(shreg_d[COLOR_BITS-1]);
        end
      end
      SEND_HIGH: begin
        if (timer_done) begin
          state_d     = SEND_LOW;
          timer_load  = 1'b1;
          timer_value = low_time(shreg[COLOR_BITS-1]);
        end
      end
      SEND_LOW: begin
        if (timer_done) begin
          timer_load = 1'b1;
          if (bit_idx != '0) begin
            shreg_d     = shreg << 1;
            bit_idx_d   = bit_idx - 1'b1;
            state_d     = SEND_HIGH;
            timer_value = high_time(shreg[COLOR_BITS-2]);
          end else if (next_led_request == LAST_LED) begin
            led_idx_d   = '0;
            state_d     = FRAME_GAP;
            timer_value = TIMER_W'(RESET_CYCLES - 1);
          end else begin
            led_idx_d   = next_led_request + 1'b1;
            state_d     = WAIT_COLOR;
            timer_value = TIMER_W'(REQ_LATENCY);
          end
        end
      end
      default: state_d = FRAME_GAP;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= FRAME_GAP;
      shreg            <= '0;
      bit_idx          <= '0;
      next_led_request <= '0;
      gap_armed        <= 1'b0;
      strand_out       <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      state            <= state_d;
      shreg            <= shreg_d;
      bit_idx          <= bit_idx_d;
      next_led_request <= led_idx_d;
      gap_armed        <= 1'b1;
      strand_out       <= (state_d == SEND_HIGH);
      busy             <= (state_d == SEND_HIGH) || (state_d == SEND_LOW);
      frame_done       <= (state_d == FRAME_GAP) && timer_done_next;
    end
  end

endmodule

// File: tb/tb_led_strand_driver.sv
// Self-checking bench: random colours per frame, pulse-width decode of the
// serial line against a frame-level timing model.
module tb_led_strand_driver;

  localparam int NUM   = 3;
  localparam int AW    = 2;
  localparam int T0H   = 2;
  localparam int T0L   = 4;
  localparam int T1H   = 4;
  localparam int T1L   = 2;
  localparam int RST_C = 20;
  localparam int LAT   = 2;
  localparam int STALL = 50;

  typedef logic [23:0] frame_t [NUM];

  logic          clk;
  logic          rst;
  logic [7:0]    green_in, red_in, blue_in;
  logic          color_valid;
  logic [AW-1:0] next_led_request;
  logic          strand_out;
  logic          frame_done;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int fidx  = 0;

  logic [23:0] tbl [NUM];
  logic [23:0] sel;

  int done_cnt = 0;
  int req_log[$];
  logic [AW-1:0] last_req = '0;

  led_strand_driver #(
    .NUM_LEDS(NUM), .T0H_CYCLES(T0H), .T0L_CYCLES(T0L), .T1H_CYCLES(T1H),
    .T1L_CYCLES(T1L), .RESET_CYCLES(RST_C), .REQ_LATENCY(LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .green_in         (green_in),
    .red_in           (red_in),
    .blue_in          (blue_in),
    .color_valid      (color_valid),
    .next_led_request (next_led_request),
    .strand_out       (strand_out),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Colour source: table lookup by requested index.
  always_comb begin
    sel = tbl[0];
    for (int i = 0; i < NUM; i++)
      if (int'(next_led_request) == i) sel = tbl[i];
  end
  assign green_in = sel[23:16];
  assign red_in   = sel[15:8];
  assign blue_in  = sel[7:0];

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (next_led_request !== last_req) begin
      req_log.push_back(int'(next_led_request));
      last_req = next_led_request;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int observed, input int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Counts negedge samples at level lvl from the current one; stops on the first other level.
  task automatic measure_level(input logic lvl, input int limit, output int n);
    n = 0;
    while (strand_out === lvl && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < NUM; i++) f[i] = 24'($urandom);
  endtask

  function automatic int model_frame_cycles(input frame_t f);
    int c;
    c = RST_C + NUM * (LAT + 1);
    for (int i = 0; i < NUM; i++)
      for (int b = 0; b < 24; b++)
        c += f[i][b] ? (T1H + T1L) : (T0H + T0L);
    return c;
  endfunction

  // Called at the first negedge after the last reset edge; ends at the first high sample.
  task automatic measure_gap(input string tag);
    int low, fd_at, fd_n, req_bad;
    low = 0; fd_at = -1; fd_n = 0; req_bad = 0;
    while (strand_out === 1'b0 && low < 500) begin
      if (frame_done === 1'b1) begin
        fd_n++;
        fd_at = low;
      end
      if (next_led_request !== '0) req_bad++;
      low++;
      @(negedge clk);
    end
    check({tag, "_first_high"}, low, RST_C + LAT + 1);
    check({tag, "_done_at"}, fd_at, RST_C - 1);
    check({tag, "_done_count"}, fd_n, 1);
    check({tag, "_req_nonzero"}, req_bad, 0);
  endtask

  // Entered at the first high sample of LED 0; leaves at the first high of the next frame.
  // stall_led > 0 withholds color_valid before that LED's sample point.
  task automatic run_frame(input frame_t cur, input frame_t nxt, input int stall_led);
    int hi, lo, exp_lo, txl, frame_cycles, exp_cycles, timing_bad, busy_bad, code;
    logic [23:0] got;
    logic bitv;
    done_cnt = 0;
    req_log.delete();
    frame_cycles = 0;
    exp_cycles = model_frame_cycles(cur) + ((stall_led > 0) ? (STALL - (LAT + 1)) : 0);
    for (int led = 0; led < NUM; led++) begin
      got = '0;
      timing_bad = 0;
      for (int b = 23; b >= 0; b--) begin
        bitv = cur[led][b];
        txl  = bitv ? T1L : T0L;
        if (stall_led == led + 1 && b == 0) color_valid = 1'b0;
        measure_level(1'b1, 200, hi);
        if (b == 23) tbl[led] = nxt[led];
        got = {got[22:0], (hi == T1H)};
        if (hi != (bitv ? T1H : T0H)) timing_bad++;
        if (stall_led == led + 1 && b == 0) begin
          lo = 0;
          busy_bad = 0;
          while (strand_out === 1'b0 && lo < 1000) begin
            lo++;
            if (lo > txl && busy !== 1'b0) busy_bad++;
            if (lo == txl + STALL) color_valid = 1'b1;
            @(negedge clk);
          end
          exp_lo = txl + STALL;
          check($sformatf("f%0d_stall_busy", fidx), busy_bad, 0);
        end else begin
          measure_level(1'b0, 1000, lo);
          exp_lo = txl;
          if (b == 0) exp_lo += (led == NUM - 1) ? (RST_C + LAT + 1) : (LAT + 1);
        end
        if (lo != exp_lo) timing_bad++;
        frame_cycles += hi + lo;
      end
      check($sformatf("f%0d_led%0d_grb", fidx, led), int'(got), int'(cur[led]));
      check($sformatf("f%0d_led%0d_timing", fidx, led), timing_bad, 0);
    end
    code = 0;
    foreach (req_log[i]) code = code * 10 + req_log[i];
    check($sformatf("f%0d_period", fidx), frame_cycles, exp_cycles);
    check($sformatf("f%0d_frame_done", fidx), done_cnt, 1);
    check($sformatf("f%0d_req_seq", fidx), code, 120);
    fidx++;
  endtask

  initial begin
    frame_t fixed_f, r1, r2, r3, r4, r5;
    int hi, lo;
    for (int i = 0; i < NUM; i++) fixed_f[i] = 24'h800001;
    rand_frame(r1);
    rand_frame(r2);
    rand_frame(r3);
    rand_frame(r4);
    rand_frame(r5);
    tbl = fixed_f;
    color_valid = 1'b1;
    rst = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_strand", int'(strand_out), 0);
    check("reset_req", int'(next_led_request), 0);
    check("reset_done", int'(frame_done), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    measure_gap("gap0");

    run_frame(fixed_f, fixed_f, -1);
    run_frame(fixed_f, r1, -1);
    run_frame(r1, r2, 1);
    run_frame(r2, r3, -1);

    // Skip to the 10th bit of LED 1, then reset in the middle of its high phase.
    for (int p = 0; p < 33; p++) begin
      measure_level(1'b1, 200, hi);
      measure_level(1'b0, 1000, lo);
    end
    check("pre_reset_high", int'(strand_out), 1);
    rst = 1'b1;
    tbl = r4;
    @(negedge clk);
    check("midbit_reset_strand", int'(strand_out), 0);
    check("midbit_reset_req", int'(next_led_request), 0);
    check("midbit_reset_busy", int'(busy), 0);
    rst = 1'b0;
    measure_gap("gap_after_reset");
    run_frame(r4, r5, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
